serial_adder: RTL

- Bit-serial, multi-bit adder.
- Captures two WIDTH-bit operands and a carry-in on a start handshake.
- Feeds one bit pair per cycle, LSB first, into a single full_adder instance, with a registered carry between cycles.
- Returns a WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the sequencing stage that sits directly upstream of, and consumes, the full_adder cell.

---
 rtl/serial_adder.sv | 107 ++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder driving one full_adder cell, LSB first, carry registered between bits.
// Latency WIDTH+1 cycles start-to-done; start is ignored while busy, accepted back-to-back from DONE.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, ps, ps_shift;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             accept, last;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Sum bits enter from the MSB so bit 0 lands at index 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_ps1
      assign ps_shift = fa_s;
    end else begin : g_psn
      assign ps_shift = {fa_s, ps[WIDTH-1:1]};
    end
  endgenerate

  assign accept = start && (state != ADD);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      ps     <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
        ps    <= '0;
      end else if (state == ADD) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= fa_co;
        ps    <= ps_shift;
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum_q  <= ps_shift;
          cout_q <= fa_co;
        end
      end
    end
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
